// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter: iterative multiply/divide unit that owns the HI/LO register pair.
//
// Multiplies use radix-2 shift-add and divides use restoring division. Both
// retire one bit per cycle and take WIDTH busy cycles. Moves to and from
// HI/LO complete in a single cycle.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   launch or execute `op` this cycle (ignored while busy)
//   op      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//   a       in   rs operand
//   b       in   rt operand
//   cancel  in   pipeline flush; aborts an in-flight multiply/divide
//   busy    out  high while a multiply or divide is iterating
//   done    out  one-cycle pulse after HI/LO are written by a multiply/divide
//   hi      out  HI register
//   lo      out  LO register
//   rdata   out  combinational read data: hi for MFHI, lo for MFLO, else 0
// ---------------------------------------------------------------------------
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // Multiply: upper half is the running partial product, lower half holds
    // the not-yet-consumed multiplier bits.
    // Divide: lower half holds the dividend shifting out at the top while
    // quotient bits shift in at the bottom; upper half stays zero.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;        // partial remainder for divide
    logic [WIDTH-1:0]   opb;        // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;      // negate product / quotient at the end
    logic               neg_r;      // negate remainder at the end
    logic               div_zero;   // divisor was zero

    // -----------------------------------------------------------------------
    // Launch decode: magnitudes and result signs for the signed ops
    // -----------------------------------------------------------------------
    logic             op_signed;
    logic             op_is_div;
    logic             op_is_arith;
    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // NOTE: every signal driven from always_comb gets a default first so no
    // path leaves it unassigned; an unassigned path infers a latch.
    always_comb begin
        op_signed   = 1'b0;
        op_is_div   = 1'b0;
        op_is_arith = 1'b0;
        case (op)
            OP_MULT:  begin op_is_arith = 1'b1; op_signed = 1'b1; end
            OP_MULTU: begin op_is_arith = 1'b1; end
            OP_DIV:   begin op_is_arith = 1'b1; op_signed = 1'b1; op_is_div = 1'b1; end
            OP_DIVU:  begin op_is_arith = 1'b1; op_is_div = 1'b1; end
            default:  begin op_is_arith = 1'b0; end
        endcase

        a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

        // cancel outranks a start presented in the same cycle
        accept = start && !cancel && (state != S_RUN);
    end

    // -----------------------------------------------------------------------
    // One iteration step plus the sign fix-up of its result. The fix-up is
    // taken from the step outputs so the last step and the HI/LO write share
    // one edge.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_next;
    logic               q_bit;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier bit is set, then shift right with the carry.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: bring down the next dividend bit, subtract only
        // when the divisor fits. A zero divisor always fits, which yields an
        // all-ones quotient and leaves the dividend in the remainder.
        rem_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
        if (rem_shift >= {1'b0, opb}) begin
            rem_next = rem_shift - {1'b0, opb};
            q_bit    = 1'b1;
        end else begin
            rem_next = rem_shift;
            q_bit    = 1'b0;
        end
        quo_next = {acc[WIDTH-2:0], q_bit};

        prod_fix = neg_q ? -mul_next : mul_next;
        // Divide by zero reports an all-ones quotient regardless of sign;
        // the remainder fix-up restores the original signed dividend.
        quo_fix  = div_zero ? '1 : (neg_q ? -quo_next : quo_next);
        rem_fix  = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (state == S_RUN) begin
            if (cancel) begin
                // Abandon the operation; HI/LO keep their old contents.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                if (is_div) begin
                    acc <= {{WIDTH{1'b0}}, quo_next};
                    rem <= rem_next;
                end else begin
                    acc <= mul_next;
                end

                if (cnt == LAST_STEP) begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin
            // IDLE or DONE: DONE always expires after one cycle.
            state <= S_IDLE;
            done  <= 1'b0;
            if (accept) begin
                if (op_is_arith) begin
                    acc      <= {{WIDTH{1'b0}}, a_mag};
                    rem      <= '0;
                    opb      <= b_mag;
                    is_div   <= op_is_div;
                    neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r    <= op_signed && op_is_div && a[WIDTH-1];
                    div_zero <= op_is_div && (b == '0);
                    cnt      <= '0;
                    state    <= S_RUN;
                    busy     <= 1'b1;
                end else if (op == OP_MTHI) begin
                    hi <= a;
                end else if (op == OP_MTLO) begin
                    lo <= a;
                end
                // MFHI/MFLO only read through rdata.
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read port: same-cycle view of HI/LO, so a read in DONE sees the result
    // -----------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (op == OP_MFHI) begin
            rdata = hi;
        end else if (op == OP_MFLO) begin
            rdata = lo;
        end
    end

endmodule
